// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - ROM/datapath-side signal bundle for the microprogram sequencer
interface micro_sequencer_if;
    logic [17:0] uinst;
    logic [3:0]  opcode;
    logic        flag_z;
    logic        flag_c;
    logic        mem_ready;
    logic        halt;
    logic [3:0]  mpc;
    logic        waiting;
    logic        stack_err;

    modport master (
        input  uinst, opcode, flag_z, flag_c, mem_ready, halt,
        output mpc, waiting, stack_err
    );

    modport slave (
        output uinst, opcode, flag_z, flag_c, mem_ready, halt,
        input  mpc, waiting, stack_err
    );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram counter with dispatch, branch, call stack and wait-states
module micro_sequencer #(
    parameter int         STACK_DEPTH   = 2,
    parameter logic [3:0] DISPATCH_BASE = 4'd4
) (
    input  logic clock,
    input  logic reset_n,
    micro_sequencer_if.master bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_NEXT     = 3'b000,
        OP_JUMP     = 3'b001,
        OP_DISPATCH = 3'b010,
        OP_BZ       = 3'b011,
        OP_BC       = 3'b100,
        OP_CALL     = 3'b101,
        OP_RET      = 3'b110,
        OP_FETCH    = 3'b111
    } seq_op_t;

    logic [3:0]      mpc_q;
    logic [SP_W-1:0] sp;
    logic [3:0]      stack_mem [STACK_DEPTH];
    logic            err_q;

    seq_op_t    seq_op;
    logic       wait_bit;
    logic [3:0] target;
    logic [3:0] mpc_inc;
    logic       stall;
    logic [3:0] top_entry;
    logic [3:0] next_mpc;
    logic       do_push;
    logic       do_pop;
    logic       set_err;
    logic       unused_uinst;

    assign seq_op       = seq_op_t'(bus.uinst[17:15]);
    assign wait_bit     = bus.uinst[14];
    assign target       = bus.uinst[3:0];
    assign unused_uinst = ^bus.uinst[13:4];
    assign mpc_inc      = mpc_q + 4'd1;

    // Halt outranks the memory wait; either one freezes all state for this edge.
    assign stall = bus.halt | (wait_bit & ~bus.mem_ready);

    assign bus.mpc       = mpc_q;
    assign bus.waiting   = wait_bit & ~bus.mem_ready & ~bus.halt;
    assign bus.stack_err = err_q;

    // Select the top-of-stack entry (entry[sp-1]) without an oversized array index.
    always_comb begin
        top_entry = 4'd0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) begin
                top_entry = stack_mem[i];
            end
        end
    end

    // Decode seq_op into the next address and the stack side effects.
    always_comb begin
        next_mpc = mpc_inc;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        set_err  = 1'b0;
        unique case (seq_op)
            OP_NEXT:     next_mpc = mpc_inc;
            OP_JUMP:     next_mpc = target;
            OP_DISPATCH: next_mpc = DISPATCH_BASE + bus.opcode;
            OP_BZ:       next_mpc = bus.flag_z ? target : mpc_inc;
            OP_BC:       next_mpc = bus.flag_c ? target : mpc_inc;
            OP_CALL: begin
                // A full stack drops the return address but the jump still happens.
                next_mpc = target;
                if (sp != SP_FULL) begin
                    do_push = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
            end
            OP_RET: begin
                if (sp != '0) begin
                    do_pop   = 1'b1;
                    next_mpc = top_entry;
                end else begin
                    set_err  = 1'b1;
                    next_mpc = 4'd0;
                end
            end
            OP_FETCH:    next_mpc = 4'd0;
        endcase
    end

    // Register mpc, stack pointer, stack contents and the sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mpc_q <= 4'd0;
            sp    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= 4'd0;
            end
        end else if (!stall) begin
            mpc_q <= next_mpc;
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp - SP_W'(1);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (do_push && sp == SP_W'(i)) begin
                    stack_mem[i] <= mpc_inc;
                end
            end
        end
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Generates the 4-bit microprogram counter (mpc) that addresses the 16-entry microcode ROM, and consumes the 18-bit microinstruction the ROM returns.
- Sits directly upstream of the ROM: mpc out, microinstruction back in the same cycle (ROM is combinational).
- Supports sequential step, jump, opcode dispatch, conditional branch, one-deep-or-more subroutine call/return, memory wait-states and halt.

Parameters:
- STACK_DEPTH, 2, number of return-address entries (1..4).
- DISPATCH_BASE, 4'd4, mpc base added to opcode on DISPATCH (sum taken mod 16).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- uinst  input  18  current microinstruction from ROM for the present mpc.
- opcode  input  4  opcode field of the instruction register.
- flag_z  input  1  ALU zero flag.
- flag_c  input  1  ALU carry flag.
- mem_ready  input  1  memory handshake; high when the pending access completes.
- halt  input  1  freeze request.
- mpc  output  4  registered microprogram counter, drives ROM address.
- waiting  output  1  combinational; high while stalled on mem_ready.
- stack_err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Microinstruction fields used here:
  - uinst[17:15] seq_op.
  - uinst[14] WAIT.
  - uinst[3:0] target.
  - All other bits are ignored by this block.
- seq_op encoding; next mpc is:
  - 000 NEXT: mpc+1.
  - 001 JUMP: target.
  - 010 DISPATCH: DISPATCH_BASE+opcode.
  - 011 BZ: target if flag_z, else mpc+1.
  - 100 BC: target if flag_c, else mpc+1.
  - 101 CALL: push mpc+1, go to target.
  - 110 RET: pop into mpc.
  - 111 FETCH: 0.
- All 4-bit address arithmetic wraps mod 16: mpc=15 with NEXT gives 0; DISPATCH_BASE=12 with opcode=6 gives 2.
- Reset (reset_n low, any time, including mid-wait or mid-call):
  - mpc=0, stack pointer=0, all stack entries=0, stack_err=0.
  - waiting follows its equation (normally 0 since ROM word 0 has WAIT clear).
- Update priority at each rising edge, highest first:
  - reset.
  - halt=1: mpc, stack and stack_err hold.
  - WAIT=1 and mem_ready=0: hold, no stack change.
  - Otherwise apply seq_op.
- waiting = WAIT & ~mem_ready & ~halt.
- Latency: mpc changes one edge after the microinstruction is presented. flag_z, flag_c, opcode and mem_ready are sampled at that same edge. No extra pipeline stage.
- WAIT handshake:
  - The word is held for as many cycles as mem_ready is low.
  - On the first edge with mem_ready=1 the seq_op of that word executes once.
  - mem_ready high on the first cycle means zero wait.
- Stack is LIFO with pointer sp in 0..STACK_DEPTH:
  - CALL with sp<STACK_DEPTH: write entry[sp]=mpc+1 (mod 16), sp+1.
  - CALL with sp==STACK_DEPTH (full): no push, stack_err<=1, jump to target still taken.
  - RET with sp>0: mpc<=entry[sp-1], sp-1.
  - RET with sp==0 (empty): stack_err<=1, mpc<=0.
- stack_err is cleared only by reset.
- Undefined/X uinst is never expected; no recovery required.

Test Plan:
- Reset then NEXT words at all addresses, halt=0, mem_ready=1 -> mpc counts 0,1,…,15,0; reset_n pulse low mid-sequence at mpc=9 -> mpc=0 immediately, before any clock edge.
- DISPATCH with opcode=3, DISPATCH_BASE=4 -> mpc=7; opcode=13 -> mpc=1 (wrap).
- BZ target=9 at mpc=2: flag_z=1 -> mpc=9; flag_z=0 -> mpc=3. Repeat with BC/flag_c, same values.
- WAIT word at mpc=5, mem_ready low 3 cycles -> mpc stays 5 and waiting=1 for 3 cycles; mem_ready high -> seq_op executes once, waiting=0. Assert halt during the wait -> waiting=0, mpc holds.
- CALL target=10 at mpc=6, then RET at 10 -> mpc 10 then 7. Nested CALLs beyond STACK_DEPTH=2 -> third CALL still jumps, stack_err=1. Later RET pops the second return address.
- RET with empty stack after reset -> mpc=0, stack_err=1, remains 1 until reset_n low.
